pwm_motion_sequencer: RTL
=========================

Name: pwm_motion_sequencer

Overview:
- Command-driven duty-cycle sequencer that feeds the `duty` input of the 100-step PWM generator (for example, the cuckoo bird servo or bellows motor).
- Each accepted command runs one motion: ramp from REST_DUTY to a target duty at a programmable rate, hold for a programmed number of ticks, then ramp back to REST_DUTY.
- Sits between the CPU-side register interface and the PWM generator. It supports abort and signals completion with a one-cycle pulse.

Parameters:
- SYS_CLK_FREQ, 100_000_000: system clock frequency in Hz (documentation only; TICK_DIV is the parameter actually used).
- TICK_DIV, 100_000: clocks per motion tick (1 ms at 100 MHz); minimum value 2.
- DUTY_STEP, 100: PWM full-scale value; duty is clamped to this.
- REST_DUTY, 0: idle/rest duty value; must be <= DUTY_STEP.

Ports:
- clk  in  1  system clock; all registers update on the falling edge, matching the PWM generator.
- reset_p  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_target  in  7  target duty; values > DUTY_STEP are clamped to DUTY_STEP.
- cmd_rate  in  4  duty units per tick; 0 is treated as 1.
- cmd_hold  in  16  hold time in ticks.
- abort  in  1  level; forces ramp-down.
- duty  out  7  duty value to the PWM generator.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at the end of a motion.

Behaviour:
- Reset values: state=IDLE, duty=REST_DUTY, done=0, tick counter=0. busy=0 and cmd_ready=1 follow from IDLE.
- Reset mid-motion returns duty to REST_DUTY immediately; no ramp-down is performed.
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick is asserted on the edge where count==TICK_DIV-1, then the counter wraps to 0.
  - Counter clears on command accept and on every state change.
- Handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - On accept: latch the clamped target, the effective rate, and cmd_hold; state goes to RAMP_UP.
  - cmd_valid outside IDLE is ignored; no queueing.
- RAMP_UP:
  - On each tick, duty moves toward the target by the rate. Moving up: duty = min(duty+rate, target). Moving down (target < REST_DUTY): duty = max(duty-rate, target). Never overshoot.
  - On the edge where duty becomes equal to the target, go to HOLD.
  - If duty already equals the target on entry, go to HOLD on the next edge without waiting for a tick.
- HOLD:
  - duty is constant.
  - On the edge of the cmd_hold-th tick, go to RAMP_DOWN.
  - If cmd_hold==0, go to RAMP_DOWN on the next edge.
- RAMP_DOWN:
  - Step toward REST_DUTY by the rate on each tick, saturating at REST_DUTY.
  - On the edge where duty reaches REST_DUTY, go to IDLE and register done=1 for exactly one clock.
  - If duty already equals REST_DUTY on entry, go to IDLE on the next edge, with done asserted.
- Abort:
  - While abort=1 in RAMP_UP or HOLD, go to RAMP_DOWN on the next edge, starting from the current duty.
  - abort in RAMP_DOWN has no effect.
  - abort in IDLE blocks acceptance: cmd_ready=0 while abort=1 in IDLE.
  - An aborted motion still ends with a done pulse.
- Simultaneous events:
  - abort takes priority over a tick in the same cycle; the duty step for that tick is not applied.
  - done and cmd_ready are both high in the first IDLE cycle. A new command may be accepted on that edge.
- Width and arithmetic:
  - Intermediate sums are 8 bits (duty 7 bits + rate 4 bits, max 127+15) so that saturation is exact.
  - Hold counter is 16 bits and must not wrap before reaching cmd_hold.

Test Plan:
1. TICK_DIV=4, accept at edge E0 with target=30, rate=10, hold=2 → duty 10@E4, 20@E8, 30@E12 (HOLD); RAMP_DOWN@E20; duty 20@E24, 10@E28, 0@E32 (IDLE); done high for one clock after E32; busy high from E0 to E32.
2. Target=25, rate=10 → duty 10, 20, 25 (saturates, no overshoot); ramp down 15, 5, 0.
3. Target=120, rate=0 → target clamped to 100, rate treated as 1; duty reaches 100 after 100 ticks; hold=0 goes straight to RAMP_DOWN.
4. abort asserted during HOLD at duty=30 → RAMP_DOWN the next edge; duty reaches 0; done pulse. cmd_valid during the motion is not accepted; cmd_ready stays 0.
5. abort coinciding with a RAMP_UP tick at duty=20 → duty stays 20 and state goes to RAMP_DOWN; back-to-back command with cmd_valid held high is accepted in the done cycle.
6. reset_p pulsed mid-RAMP_UP (asynchronously, between edges) → duty=REST_DUTY, busy=0, done=0 immediately; no done pulse follows.

Source files
------------

// File: rtl/pwm_motion_sequencer_if.sv
// Command/status bundle between the register interface and the motion sequencer.
// The master drives commands and abort; the slave returns duty and status.
interface pwm_motion_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_target;
  logic [3:0]  cmd_rate;
  logic [15:0] cmd_hold;
  logic        abort;
  logic [6:0]  duty;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_target, cmd_rate, cmd_hold, abort,
    input  cmd_ready, duty, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_rate, cmd_hold, abort,
    output cmd_ready, duty, busy, done
  );
endinterface

// File: rtl/pwm_motion_sequencer.sv
// Motion sequencer for a 100-step PWM generator: ramp up to a target duty, hold,
// ramp back to rest, with abort and a one-cycle done pulse. Falling-edge clocked.
module pwm_motion_sequencer #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int TICK_DIV     = 100_000,
  parameter int DUTY_STEP    = 100,
  parameter int REST_DUTY    = 0
) (
  input  logic                  clk,
  input  logic                  reset_p,
  pwm_motion_sequencer_if.slave bus
);

  if (TICK_DIV < 2 || REST_DUTY > DUTY_STEP || DUTY_STEP > 127 || SYS_CLK_FREQ <= 0) begin : g_param_check
    $error("pwm_motion_sequencer: illegal parameter combination");
  end

  localparam int         TW   = $clog2(TICK_DIV);
  localparam logic [6:0] REST = 7'(REST_DUTY);
  localparam logic [6:0] FULL = 7'(DUTY_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     duty_q, duty_d;
  logic [6:0]     target_q, target_d;
  logic [3:0]     rate_q, rate_d;
  logic [15:0]    hold_q, hold_d;
  logic [15:0]    hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic           done_q, done_d;
  logic           tick_s;
  logic           cmd_ready_s;
  logic [6:0]     step_s;
  logic [16:0]    hold_next_s;

  // One rate-sized step from cur toward goal, never passing goal; 8-bit sums keep saturation exact.
  function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] goal,
                                             input logic [3:0] rate);
    logic [7:0] sum;
    logic [7:0] floor_lim;
    sum       = {1'b0, cur} + {4'b0000, rate};
    floor_lim = {1'b0, goal} + {4'b0000, rate};
    if (cur < goal) begin
      step_toward = (sum >= {1'b0, goal}) ? goal : sum[6:0];
    end else if ({1'b0, cur} >= floor_lim) begin
      step_toward = cur - {3'b000, rate};
    end else begin
      step_toward = goal;
    end
  endfunction

  assign tick_s        = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign cmd_ready_s   = (state_q == IDLE) && !bus.abort;
  assign step_s        = step_toward(duty_q, (state_q == RAMP_DOWN) ? REST : target_q, rate_q);
  assign hold_next_s   = {1'b0, hold_cnt_q} + 17'd1;

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.busy      = (state_q != IDLE);
  assign bus.duty      = duty_q;
  assign bus.done      = done_q;

  // Next-state, datapath and tick-counter logic.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    rate_d     = rate_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_s) begin
          target_d = (bus.cmd_target > FULL) ? FULL : bus.cmd_target;
          rate_d   = (bus.cmd_rate == 4'd0) ? 4'd1 : bus.cmd_rate;
          hold_d   = bus.cmd_hold;
          state_d  = RAMP_UP;
        end else begin
          state_d = IDLE;
        end
      end
      RAMP_UP: begin
        // abort wins over a coincident tick: no step is applied
        if (bus.abort) begin
          state_d = RAMP_DOWN;
        end else if (duty_q == target_q) begin
          state_d = HOLD;
        end else if (tick_s) begin
          duty_d  = step_s;
          state_d = (step_s == target_q) ? HOLD : RAMP_UP;
        end else begin
          state_d = RAMP_UP;
        end
      end
      HOLD: begin
        if (bus.abort || hold_q == 16'd0) begin
          state_d = RAMP_DOWN;
        end else if (tick_s) begin
          if (hold_next_s == {1'b0, hold_q}) begin
            state_d = RAMP_DOWN;
          end else begin
            hold_cnt_d = hold_next_s[15:0];
          end
        end else begin
          state_d = HOLD;
        end
      end
      RAMP_DOWN: begin
        if (duty_q == REST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick_s) begin
          duty_d = step_s;
          if (step_s == REST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP_DOWN;
          end
        end else begin
          state_d = RAMP_DOWN;
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = REST;
      end
    endcase
    if (state_d != state_q) begin
      hold_cnt_d = 16'd0;
    end else begin
      hold_cnt_d = hold_cnt_d;
    end
    if (state_d != state_q || tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // State and datapath registers, falling-edge to match the PWM generator.
  always_ff @(negedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= IDLE;
      duty_q     <= REST;
      target_q   <= REST;
      rate_q     <= 4'd1;
      hold_q     <= 16'd0;
      hold_cnt_q <= 16'd0;
      tick_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      rate_q     <= rate_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      done_q     <= done_d;
    end
  end

endmodule
